// File: rtl/river_crossing_ctrl.sv
// Farmer/cabbage/goat/wolf river-crossing game controller.
// Holds bank positions {F,C,G,W}, times each boat crossing and declares win/loss.
module river_crossing_ctrl #(
    parameter int CROSS_CYCLES = 4,
    parameter int MOVE_W       = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              restart,
    input  logic              move_valid,
    input  logic [1:0]        move_sel,
    output logic              move_ready,
    output logic [3:0]        pos,
    output logic              alarm,
    output logic              win,
    output logic              lost,
    output logic              illegal,
    output logic [MOVE_W-1:0] move_count
);

    localparam int TW = (CROSS_CYCLES > 1) ? $clog2(CROSS_CYCLES) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'(CROSS_CYCLES - 1);

    typedef enum logic [1:0] {PLAY, CROSS, WON, LOST} state_t;

    state_t            state, state_nxt;
    logic [3:0]        pos_nxt, pos_new;
    logic [MOVE_W-1:0] cnt_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic [1:0]        sel_q, sel_nxt;
    logic              illegal_nxt;
    logic [3:0]        req_mask;
    logic              legal;

    function automatic logic unsafe(input logic [3:0] p);
        return ((p[1] == p[0]) && (p[3] != p[1])) ||
               ((p[2] == p[1]) && (p[3] != p[1]));
    endfunction

    // Passenger bit position within {F,C,G,W}; farmer alone selects nothing.
    function automatic logic [3:0] sel_mask(input logic [1:0] s);
        logic [3:0] m;
        case (s)
            2'b01:   m = 4'b0100;
            2'b10:   m = 4'b0010;
            2'b11:   m = 4'b0001;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    assign req_mask = sel_mask(move_sel);
    assign legal    = (req_mask == 4'b0000) || ((|(pos & req_mask)) == pos[3]);
    assign pos_new  = pos ^ (4'b1000 | sel_mask(sel_q));

    always_comb begin
        state_nxt   = state;
        pos_nxt     = pos;
        cnt_nxt     = move_count;
        timer_nxt   = timer;
        sel_nxt     = sel_q;
        illegal_nxt = 1'b0;
        if (restart) begin
            state_nxt = PLAY;
            pos_nxt   = 4'b0000;
            cnt_nxt   = '0;
            timer_nxt = '0;
        end else begin
            case (state)
                PLAY: begin
                    if (move_valid) begin
                        if (legal) begin
                            sel_nxt   = move_sel;
                            timer_nxt = T_LOAD;
                            state_nxt = CROSS;
                        end else begin
                            illegal_nxt = 1'b1;
                        end
                    end
                end
                CROSS: begin
                    if (timer != '0) begin
                        timer_nxt = timer - TW'(1);
                    end else begin
                        pos_nxt = pos_new;
                        cnt_nxt = (move_count == '1) ? move_count : move_count + MOVE_W'(1);
                        if (unsafe(pos_new))
                            state_nxt = LOST;
                        else if (pos_new == 4'b1111)
                            state_nxt = WON;
                        else
                            state_nxt = PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PLAY;
            pos        <= 4'b0000;
            move_count <= '0;
            timer      <= '0;
            sel_q      <= 2'b00;
            illegal    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pos        <= pos_nxt;
            move_count <= cnt_nxt;
            timer      <= timer_nxt;
            sel_q      <= sel_nxt;
            illegal    <= illegal_nxt;
        end
    end

    assign move_ready = (state == PLAY);
    assign alarm      = unsafe(pos);
    assign win        = (state == WON);
    assign lost       = (state == LOST);

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Directed bench for river_crossing_ctrl: game play, illegal moves, restart, reset, saturation.
module tb_river_crossing_ctrl;

    localparam int CC = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       restart = 1'b0, move_valid = 1'b0;
    logic [1:0] move_sel = 2'b00;
    logic       move_ready, alarm, win, lost, illegal;
    logic [3:0] pos;
    logic [4:0] move_count;

    logic       s_restart = 1'b0, s_valid = 1'b0;
    logic [1:0] s_sel = 2'b00;
    logic       s_ready, s_alarm, s_win, s_lost, s_illegal;
    logic [3:0] s_pos;
    logic [2:0] s_cnt;

    int n_vec = 0;
    int n_bad = 0;

    river_crossing_ctrl #(.CROSS_CYCLES(CC), .MOVE_W(5)) u_dut (
        .clk(clk), .reset_n(reset_n), .restart(restart), .move_valid(move_valid),
        .move_sel(move_sel), .move_ready(move_ready), .pos(pos), .alarm(alarm),
        .win(win), .lost(lost), .illegal(illegal), .move_count(move_count));

    river_crossing_ctrl #(.CROSS_CYCLES(1), .MOVE_W(3)) u_sat (
        .clk(clk), .reset_n(reset_n), .restart(s_restart), .move_valid(s_valid),
        .move_sel(s_sel), .move_ready(s_ready), .pos(s_pos), .alarm(s_alarm),
        .win(s_win), .lost(s_lost), .illegal(s_illegal), .move_count(s_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepted move: ready low for CC cycles, pos lands on the CC-th edge.
    task automatic do_move(input logic [1:0] sel, input logic [3:0] exp_pos,
                           input logic [31:0] exp_cnt, input logic noise);
        move_valid = 1'b1;
        move_sel   = sel;
        tick();
        move_valid = noise;
        move_sel   = noise ? ~sel : sel;
        chk("acc_ready", 32'(move_ready), 32'd0);
        for (int i = 0; i < CC - 1; i++) begin
            tick();
            chk("cross_ready", 32'(move_ready), 32'd0);
            chk("cross_illegal", 32'(illegal), 32'd0);
        end
        tick();
        move_valid = 1'b0;
        chk("move_pos", 32'(pos), 32'(exp_pos));
        chk("move_cnt", 32'(move_count), exp_cnt);
    endtask

    initial begin
        // reset
        #12;
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_ready", 32'(move_ready), 32'd1);
        reset_n = 1'b1;
        tick();
        chk("rst_cnt", 32'(move_count), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_win", 32'(win), 32'd0);
        chk("rst_lost", 32'(lost), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);

        // solution path, with noise on the bus during the first crossing
        do_move(2'b10, 4'b1010, 1, 1'b1);
        chk("g1_alarm", 32'(alarm), 32'd0);
        chk("g1_ready", 32'(move_ready), 32'd1);
        do_move(2'b00, 4'b0010, 2, 1'b0);

        // goat on far bank, farmer near: rejected
        move_valid = 1'b1; move_sel = 2'b10;
        tick();
        move_valid = 1'b0;
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_pos", 32'(pos), 32'b0010);
        chk("ill_cnt", 32'(move_count), 32'd2);
        chk("ill_ready", 32'(move_ready), 32'd1);
        tick();
        chk("ill_clear", 32'(illegal), 32'd0);
        chk("ill_ready2", 32'(move_ready), 32'd1);

        do_move(2'b11, 4'b1011, 3, 1'b0);
        chk("w_alarm", 32'(alarm), 32'd0);
        do_move(2'b10, 4'b0001, 4, 1'b0);
        chk("g2_alarm", 32'(alarm), 32'd0);
        do_move(2'b01, 4'b1101, 5, 1'b0);
        chk("c_alarm", 32'(alarm), 32'd0);
        do_move(2'b00, 4'b0101, 6, 1'b0);
        chk("f_alarm", 32'(alarm), 32'd0);
        do_move(2'b10, 4'b1111, 7, 1'b0);
        chk("won_win", 32'(win), 32'd1);
        chk("won_lost", 32'(lost), 32'd0);
        chk("won_ready", 32'(move_ready), 32'd0);
        move_valid = 1'b1; move_sel = 2'b00;
        tick(); tick();
        move_valid = 1'b0;
        chk("won_hold_pos", 32'(pos), 32'hF);
        chk("won_hold_cnt", 32'(move_count), 32'd7);

        // lose: farmer leaves alone
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_pos", 32'(pos), 32'd0);
        chk("rs_cnt", 32'(move_count), 32'd0);
        chk("rs_win", 32'(win), 32'd0);
        chk("rs_ready", 32'(move_ready), 32'd1);
        do_move(2'b00, 4'b1000, 1, 1'b0);
        chk("lost_alarm", 32'(alarm), 32'd1);
        chk("lost_lost", 32'(lost), 32'd1);
        chk("lost_win", 32'(win), 32'd0);
        chk("lost_ready", 32'(move_ready), 32'd0);
        move_valid = 1'b1; move_sel = 2'b00;
        tick(); tick();
        move_valid = 1'b0;
        chk("lost_hold_pos", 32'(pos), 32'b1000);
        chk("lost_hold_ill", 32'(illegal), 32'd0);
        chk("lost_hold_cnt", 32'(move_count), 32'd1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("lost_rs_pos", 32'(pos), 32'd0);
        chk("lost_rs_ready", 32'(move_ready), 32'd1);
        chk("lost_rs_lost", 32'(lost), 32'd0);

        // restart two cycles into a crossing aborts it
        move_valid = 1'b1; move_sel = 2'b10;
        tick();
        move_valid = 1'b0;
        tick(); tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("abort_pos", 32'(pos), 32'd0);
        chk("abort_ready", 32'(move_ready), 32'd1);
        chk("abort_cnt", 32'(move_count), 32'd0);
        for (int i = 0; i < CC + 1; i++) tick();
        chk("abort_pos_late", 32'(pos), 32'd0);

        // restart beats a simultaneous move request
        restart = 1'b1; move_valid = 1'b1; move_sel = 2'b10;
        tick();
        restart = 1'b0; move_valid = 1'b0;
        chk("rsmv_ready", 32'(move_ready), 32'd1);
        for (int i = 0; i < CC + 1; i++) tick();
        chk("rsmv_pos", 32'(pos), 32'd0);
        chk("rsmv_cnt", 32'(move_count), 32'd0);

        // async reset mid-crossing
        move_valid = 1'b1; move_sel = 2'b10;
        tick();
        move_valid = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ready", 32'(move_ready), 32'd1);
        chk("arst_pos", 32'(pos), 32'd0);
        #3 reset_n = 1'b1;
        for (int i = 0; i < CC + 1; i++) tick();
        chk("arst_pos_late", 32'(pos), 32'd0);

        // 3-bit counter, 1-cycle crossings: saturate at 7
        for (int i = 0; i < 9; i++) begin
            s_valid = 1'b1; s_sel = 2'b10;
            tick();
            s_valid = 1'b0;
            chk("sat_busy", 32'(s_ready), 32'd0);
            tick();
            chk("sat_pos", 32'(s_pos), (i % 2 == 0) ? 32'b1010 : 32'b0000);
            chk("sat_cnt", 32'(s_cnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
        end
        chk("sat_alarm", 32'(s_alarm), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
